// File: rtl/id_ex_stage_pkg.sv
// Shared constants, the ID/EX payload struct and small helpers for the ID/EX pipeline register.
// Encoding 0 of add2_sel/alu_op is chosen so an all-zero payload is a harmless bubble.
package id_ex_stage_pkg;

  localparam int XLEN         = 32;
  localparam int REG_W        = 5;
  localparam int BUBBLE_CNT_W = 16;

  localparam logic [1:0] ADD2_RS2 = 2'd0;
  localparam logic [1:0] ADD2_IMM = 2'd1;
  localparam logic [1:0] ADD2_0   = 2'd2;

  localparam logic [1:0] ALU_OP_R   = 2'd0;
  localparam logic [1:0] ALU_OP_I   = 2'd1;
  localparam logic [1:0] ALU_OP_ADD = 2'd2;
  localparam logic [1:0] ALU_OP_SUB = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rs2_used;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             branch;
    logic             pc_sel;
    logic             jalr_en;
    logic             reg_write;
    logic             memtoreg;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       add2_sel;
    logic [1:0]       alu_op;
  } id_ex_t;

  // Bubble: no valid bit, no side-effecting control, datapath cleared.
  function automatic id_ex_t bubble_pkt();
    id_ex_t p;
    p          = '0;
    p.add2_sel = ADD2_RS2;
    p.alu_op   = ALU_OP_R;
    return p;
  endfunction

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detection: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic             id_rs2_used_i,
  output logic             lu_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    // x0 is never written, so a load to x0 cannot create a hazard.
    ex_is_load = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0);
    rs1_hit    = (id_rs1_i == ex_rd_i);
    rs2_hit    = id_rs2_used_i && (id_rs2_i == ex_rd_i);
    lu_o       = ex_is_load && id_valid_i && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
// Load-use detection and the bubble counter exist only when ID_EX_LOAD_USE_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid_i,
  input  logic [XLEN-1:0]         id_pc_i,
  input  logic [XLEN-1:0]         id_rs1_data_i,
  input  logic [XLEN-1:0]         id_rs2_data_i,
  input  logic [XLEN-1:0]         id_imm_i,
  input  logic [REG_W-1:0]        id_rs1_i,
  input  logic [REG_W-1:0]        id_rs2_i,
  input  logic [REG_W-1:0]        id_rd_i,
  input  logic                    id_rs2_used_i,
  input  logic [2:0]              id_funct3_i,
  input  logic                    id_funct7b5_i,
  input  logic                    id_branch_i,
  input  logic                    id_pc_sel_i,
  input  logic                    id_jalr_en_i,
  input  logic                    id_reg_write_i,
  input  logic                    id_memtoreg_i,
  input  logic                    id_mem_read_i,
  input  logic                    id_mem_write_i,
  input  logic [1:0]              id_add2_sel_i,
  input  logic [1:0]              id_alu_op_i,
  input  logic                    bxx_flush_i,
  input  logic                    ex_hold_i,
  output logic                    ex_valid_o,
  output logic [XLEN-1:0]         ex_pc_o,
  output logic [XLEN-1:0]         ex_rs1_data_o,
  output logic [XLEN-1:0]         ex_rs2_data_o,
  output logic [XLEN-1:0]         ex_imm_o,
  output logic [REG_W-1:0]        ex_rs1_o,
  output logic [REG_W-1:0]        ex_rs2_o,
  output logic [REG_W-1:0]        ex_rd_o,
  output logic                    ex_rs2_used_o,
  output logic [2:0]              ex_funct3_o,
  output logic                    ex_funct7b5_o,
  output logic                    ex_branch_o,
  output logic                    ex_pc_sel_o,
  output logic                    ex_jalr_en_o,
  output logic                    ex_reg_write_o,
  output logic                    ex_memtoreg_o,
  output logic                    ex_mem_read_o,
  output logic                    ex_mem_write_o,
  output logic [1:0]              ex_add2_sel_o,
  output logic [1:0]              ex_alu_op_o,
  output logic                    stall_o,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt_o
);

  id_ex_t id_pkt;
  id_ex_t stage_q;
  id_ex_t stage_d;
  logic   lu;

  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = id_valid_i;
    id_pkt.pc       = id_pc_i;
    id_pkt.rs1_data = id_rs1_data_i;
    id_pkt.rs2_data = id_rs2_data_i;
    id_pkt.imm      = id_imm_i;
    id_pkt.rs1      = id_rs1_i;
    id_pkt.rs2      = id_rs2_i;
    id_pkt.rd       = id_rd_i;
    id_pkt.rs2_used = id_rs2_used_i;
    id_pkt.funct3   = id_funct3_i;
    id_pkt.funct7b5 = id_funct7b5_i;
    id_pkt.branch   = id_branch_i;
    id_pkt.pc_sel   = id_pc_sel_i;
    id_pkt.jalr_en  = id_jalr_en_i;
    id_pkt.reg_write = id_reg_write_i;
    id_pkt.memtoreg = id_memtoreg_i;
    id_pkt.mem_read = id_mem_read_i;
    id_pkt.mem_write = id_mem_write_i;
    id_pkt.add2_sel = id_add2_sel_i;
    id_pkt.alu_op   = id_alu_op_i;
  end

`ifdef ID_EX_LOAD_USE_EN
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (stage_q.valid),
    .ex_mem_read_i (stage_q.mem_read),
    .ex_rd_i       (stage_q.rd),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs2_used_i (id_rs2_used_i),
    .lu_o          (lu)
  );

  // Counts only bubbles that are actually inserted (flush and hold take priority).
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (lu && !bxx_flush_i && !ex_hold_i) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign lu           = 1'b0;
  assign bubble_cnt_o = '0;
`endif

  always_comb begin
    stage_d = stage_q;
    if (bxx_flush_i) begin
      stage_d = bubble_pkt();
    end else if (ex_hold_i) begin
      stage_d = stage_q;
    end else if (lu) begin
      stage_d = bubble_pkt();
    end else begin
      stage_d = id_pkt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // A flushed consumer is discarded anyway, so it must not stall the front end.
  assign stall_o = ex_hold_i | (lu & ~bxx_flush_i);

  assign ex_valid_o     = stage_q.valid;
  assign ex_pc_o        = stage_q.pc;
  assign ex_rs1_data_o  = stage_q.rs1_data;
  assign ex_rs2_data_o  = stage_q.rs2_data;
  assign ex_imm_o       = stage_q.imm;
  assign ex_rs1_o       = stage_q.rs1;
  assign ex_rs2_o       = stage_q.rs2;
  assign ex_rd_o        = stage_q.rd;
  assign ex_rs2_used_o  = stage_q.rs2_used;
  assign ex_funct3_o    = stage_q.funct3;
  assign ex_funct7b5_o  = stage_q.funct7b5;
  assign ex_branch_o    = stage_q.branch;
  assign ex_pc_sel_o    = stage_q.pc_sel;
  assign ex_jalr_en_o   = stage_q.jalr_en;
  assign ex_reg_write_o = stage_q.reg_write;
  assign ex_memtoreg_o  = stage_q.memtoreg;
  assign ex_mem_read_o  = stage_q.mem_read;
  assign ex_mem_write_o = stage_q.mem_write;
  assign ex_add2_sel_o  = stage_q.add2_sel;
  assign ex_alu_op_o    = stage_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_LOAD_USE_EN the same way the design does.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs2_used;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        branch;
    logic        pc_sel;
    logic        jalr_en;
    logic        reg_write;
    logic        memtoreg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  add2_sel;
    logic [1:0]  alu_op;
  } id_t;

  typedef struct {
    id_t         ex;
    logic [15:0] cnt;
  } exp_t;

`ifdef ID_EX_LOAD_USE_EN
  localparam bit LU_ON = 1'b1;
`else
  localparam bit LU_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bxx_flush = 1'b0;
  logic ex_hold = 1'b0;
  id_t  id = '0;

  logic        ex_valid_o, ex_rs2_used_o, ex_funct7b5_o, ex_branch_o, ex_pc_sel_o;
  logic        ex_jalr_en_o, ex_reg_write_o, ex_memtoreg_o, ex_mem_read_o, ex_mem_write_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [2:0]  ex_funct3_o;
  logic [1:0]  ex_add2_sel_o, ex_alu_op_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;
  id_t         obs;

  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;
  id_t  model_q = '0;
  logic [15:0] model_cnt = '0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id.valid), .id_pc_i(id.pc), .id_rs1_data_i(id.rs1_data),
    .id_rs2_data_i(id.rs2_data), .id_imm_i(id.imm), .id_rs1_i(id.rs1),
    .id_rs2_i(id.rs2), .id_rd_i(id.rd), .id_rs2_used_i(id.rs2_used),
    .id_funct3_i(id.funct3), .id_funct7b5_i(id.funct7b5), .id_branch_i(id.branch),
    .id_pc_sel_i(id.pc_sel), .id_jalr_en_i(id.jalr_en), .id_reg_write_i(id.reg_write),
    .id_memtoreg_i(id.memtoreg), .id_mem_read_i(id.mem_read), .id_mem_write_i(id.mem_write),
    .id_add2_sel_i(id.add2_sel), .id_alu_op_i(id.alu_op),
    .bxx_flush_i(bxx_flush), .ex_hold_i(ex_hold),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o),
    .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_rs2_used_o(ex_rs2_used_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o), .ex_branch_o(ex_branch_o),
    .ex_pc_sel_o(ex_pc_sel_o), .ex_jalr_en_o(ex_jalr_en_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_memtoreg_o(ex_memtoreg_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_add2_sel_o(ex_add2_sel_o), .ex_alu_op_o(ex_alu_op_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  assign obs = {ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o,
                ex_rs2_o, ex_rd_o, ex_rs2_used_o, ex_funct3_o, ex_funct7b5_o, ex_branch_o,
                ex_pc_sel_o, ex_jalr_en_o, ex_reg_write_o, ex_memtoreg_o, ex_mem_read_o,
                ex_mem_write_o, ex_add2_sel_o, ex_alu_op_o};

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic id_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic rs2_used, input logic is_load);
    id_t t;
    t           = '0;
    t.valid     = 1'b1;
    t.pc        = pc;
    t.rs1_data  = pc ^ 32'h1111_0000;
    t.rs2_data  = ~pc;
    t.imm       = {pc[15:0], 16'h00F4};
    t.rs1       = rs1;
    t.rs2       = rs2;
    t.rd        = rd;
    t.rs2_used  = rs2_used;
    t.reg_write = 1'b1;
    t.mem_read  = is_load;
    t.memtoreg  = is_load;
    t.funct3    = is_load ? 3'b010 : 3'b000;
    t.add2_sel  = is_load ? 2'd1 : 2'd0;
    t.alu_op    = is_load ? 2'd2 : 2'd0;
    return t;
  endfunction

  // Reference hazard rule: valid load in EX to a nonzero rd read by a valid ID instruction.
  function automatic logic model_lu(input id_t ex, input id_t dec);
    logic hit;
    hit = ex.valid && ex.mem_read && (ex.rd != 5'd0) && dec.valid &&
          ((dec.rs1 == ex.rd) || (dec.rs2_used && (dec.rs2 == ex.rd)));
    return LU_ON && hit;
  endfunction

  // Drives one ID slot (called away from the rising edge), returns at the following falling edge.
  task automatic step(input id_t nid, input logic fl, input logic hd);
    exp_t e;
    logic lu_m;
    logic stall_m;
    id        = nid;
    bxx_flush = fl;
    ex_hold   = hd;
    #1;
    lu_m    = model_lu(model_q, nid);
    stall_m = hd | (lu_m & ~fl);
    check_eq("stall", {159'd0, stall_o}, {159'd0, stall_m});
    if (fl) begin
      model_q = '0;
    end else if (hd) begin
      model_q = model_q;
    end else if (lu_m) begin
      model_q = '0;
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end else begin
      model_q = nid;
    end
    e.ex  = model_q;
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("ex_regs", obs, e.ex);
    check_eq("bubble_cnt", {144'd0, bubble_cnt_o}, {144'd0, e.cnt});
    nstep++;
    $display("step %0d flush=%b hold=%b stall=%b ex_valid=%b ex_pc=%h cnt=%h",
             nstep, fl, hd, stall_m, ex_valid_o, ex_pc_o, bubble_cnt_o);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    id_t add_x7;
    id_t lw_x7;
    id_t r;

    // Reset state.
    #12;
    check_eq("rst_regs", obs, 160'd0);
    check_eq("rst_cnt", {144'd0, bubble_cnt_o}, 160'd0);
    check_eq("rst_stall", {159'd0, stall_o}, 160'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain ADD, one-cycle latency.
    step(mk(32'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0), 1'b0, 1'b0);
    check_eq("add_pc", {128'd0, ex_pc_o}, 160'h100);
    check_eq("add_rd", {155'd0, ex_rd_o}, 160'd5);
    check_eq("add_regw", {159'd0, ex_reg_write_o}, 160'd1);
    check_eq("add_valid", {159'd0, ex_valid_o}, 160'd1);

    // LW x7 then ADD x7: one bubble, then the ADD.
    lw_x7  = mk(32'h104, 5'd2, 5'd0, 5'd7, 1'b0, 1'b1);
    add_x7 = mk(32'h108, 5'd7, 5'd3, 5'd8, 1'b1, 1'b0);
    step(lw_x7, 1'b0, 1'b0);
    step(add_x7, 1'b0, 1'b0);
    check_eq("lu_bubble_valid", {159'd0, ex_valid_o}, {159'd0, ~LU_ON});
    if (stall_o) step(add_x7, 1'b0, 1'b0);
    check_eq("lu_add_pc", {128'd0, ex_pc_o}, 160'h108);
    check_eq("lu_cnt", {144'd0, bubble_cnt_o}, {159'd0, LU_ON});

    // Load to x0 and an I-type whose unused rs2 field matches the load rd.
    step(mk(32'h10C, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h110, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(32'h114, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h118, 5'd4, 5'd7, 5'd10, 1'b0, 1'b0), 1'b0, 1'b0);
    check_eq("ityp_pc", {128'd0, ex_pc_o}, 160'h118);

    // Flush during a load-use: bubble, no stall, counter unchanged.
    step(mk(32'h11C, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h120, 5'd7, 5'd7, 5'd11, 1'b1, 1'b0), 1'b1, 1'b0);
    check_eq("flush_valid", {159'd0, ex_valid_o}, 160'd0);
    check_eq("flush_cnt", {144'd0, bubble_cnt_o}, {159'd0, LU_ON});

    // Hold for three cycles with changing inputs, then flush wins over hold.
    step(mk(32'h200, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(mk(32'h300 + 32'(i * 4), 5'd3, 5'd3, 5'd4, 1'b1, 1'b0), 1'b0, 1'b1);
    end
    check_eq("hold_pc", {128'd0, ex_pc_o}, 160'h200);
    step(mk(32'h310, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0), 1'b1, 1'b1);
    check_eq("flush_hold_valid", {159'd0, ex_valid_o}, 160'd0);

    // Load-use coinciding with hold: hold wins.
    step(mk(32'h320, 5'd1, 5'd0, 5'd6, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h324, 5'd6, 5'd0, 5'd7, 1'b0, 1'b0), 1'b0, 1'b1);

    // Mixed traffic over a tiny register set to provoke hazards.
    for (int i = 0; i < 60; i++) begin
      r          = mk(32'h1000 + 32'(i * 4), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      r.valid    = ($urandom_range(0, 7) != 0);
      r.branch   = 1'($urandom_range(0, 1));
      r.pc_sel   = 1'($urandom_range(0, 1));
      r.jalr_en  = 1'($urandom_range(0, 1));
      r.mem_write = 1'($urandom_range(0, 1));
      r.funct7b5 = 1'($urandom_range(0, 1));
      r.rs1_data = $urandom;
      step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset mid-operation, then first load after release.
    step(mk(32'h400, 5'd1, 5'd0, 5'd5, 1'b0, 1'b1), 1'b0, 1'b0);
    bxx_flush = 1'b0;
    ex_hold   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_regs", obs, 160'd0);
    check_eq("arst_cnt", {144'd0, bubble_cnt_o}, 160'd0);
    model_q   = '0;
    model_cnt = '0;
    #1;
    rst = 1'b0;
    step(mk(32'h500, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0), 1'b0, 1'b0);
    check_eq("post_rst_pc", {128'd0, ex_pc_o}, 160'h500);

`ifdef ID_EX_LOAD_USE_EN
    // Saturation: preload the counter just below the limit.
    step(mk(32'h600, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0);
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    model_cnt = 16'hFFFE;
    step(mk(32'h604, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0), 1'b0, 1'b0);
    check_eq("sat_reach", {144'd0, bubble_cnt_o}, 160'hFFFF);
    step(mk(32'h604, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0), 1'b0, 1'b0);
    step(mk(32'h608, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h60C, 5'd2, 5'd7, 5'd9, 1'b1, 1'b0), 1'b0, 1'b0);
    check_eq("sat_stay", {144'd0, bubble_cnt_o}, 160'hFFFF);
    step(mk(32'h60C, 5'd2, 5'd7, 5'd9, 1'b1, 1'b0), 1'b0, 1'b0);
`else
    // Without detection a load-use pair flows straight through.
    step(mk(32'h600, 5'd1, 5'd0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0);
    step(mk(32'h604, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0), 1'b0, 1'b0);
    check_eq("nolu_pc", {128'd0, ex_pc_o}, 160'h604);
    check_eq("nolu_cnt", {144'd0, bubble_cnt_o}, 160'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
